// File: rtl/cla_word_sequencer.sv
// cla4: 4-bit carry-lookahead adder slice.
//   A, B  : 4-bit addends
//   Cin   : carry in
//   Sum   : 4-bit sum
//   Cout  : carry out of bit 3
module cla4 (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);

    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    assign p = A ^ B;
    assign g = A & B;

    // Carries computed in parallel from generate/propagate terms
    assign c[0] = Cin;
    assign c[1] = g[0] | (p[0] & Cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & Cin);
    assign Cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & Cin);

    assign Sum = p ^ c;

endmodule

// cla_word_sequencer: W-bit add/subtract built by time-sharing one 4-bit CLA
// over NIBBLES slices, LSB slice first.
//   clk, rst           : clock, asynchronous active-high reset
//   in_valid/in_ready  : request handshake (op_a, op_b, op_sub, cin)
//   out_valid/out_ready: result handshake (sum, cout, overflow)
//   op_sub             : 0 = A+B+cin, 1 = A-B (cin ignored)
//   cout               : MSB carry out (subtract: 1 = no borrow)
//   overflow           : two's-complement signed overflow
module cla_word_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic                 op_sub,
    input  logic                 cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 overflow
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int unsigned BW = CW + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q,     state_d;
    logic [W-1:0]    a_q,         a_d;
    logic [W-1:0]    b_q,         b_d;
    logic            carry_q,     carry_d;
    logic [CW-1:0]   cnt_q,       cnt_d;
    logic [W-1:0]    sum_q,       sum_d;
    logic            cout_q,      cout_d;
    logic            overflow_q,  overflow_d;
    logic            in_ready_q,  in_ready_d;
    logic            out_valid_q, out_valid_d;

    logic [BW-1:0]   base;
    logic [3:0]      cla_a;
    logic [3:0]      cla_b;
    logic [3:0]      cla_sum;
    logic            cla_cout;

    // Bit offset of the slice currently being processed
    assign base  = {cnt_q, 2'b00};
    assign cla_a = a_q[base +: 4];
    assign cla_b = b_q[base +: 4];

    cla4 u_cla (
        .A    (cla_a),
        .B    (cla_b),
        .Cin  (carry_q),
        .Sum  (cla_sum),
        .Cout (cla_cout)
    );

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            overflow_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            overflow_q  <= overflow_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        sum_d      = sum_q;
        cout_d     = cout_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE: begin
                // in_ready_q is low for the first cycle out of reset
                if (in_valid && in_ready_q) begin
                    a_d     = op_a;
                    b_d     = op_sub ? ~op_b : op_b;
                    carry_d = op_sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[base +: 4] = cla_sum;
                carry_d          = cla_cout;
                if (cnt_q == CW'(NIBBLES - 1)) begin
                    // Counter saturates here; cleared again on acceptance
                    state_d    = DONE;
                    cout_d     = cla_cout;
                    overflow_d = (a_q[W-1] == b_q[W-1]) && (cla_sum[3] != a_q[W-1]);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake flags track the state being entered so they stay registered
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_cla_word_sequencer.sv
module tb_cla_word_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        op_sub;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        overflow;

    int checks;
    int fails;

    cla_word_sequencer #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sub    (op_sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request, wait (bounded) for out_valid, return observed result.
    // lat = edges from acceptance to out_valid, 99 on timeout.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic c, input bit retire,
                         output logic [15:0] rs, output logic rc,
                         output logic ro, output int lat);
        int guard;
        logic saved;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        op_a = a; op_b = b; op_sub = s; cin = c; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a = 16'($urandom); op_b = 16'($urandom);
        op_sub = 1'($urandom); cin = 1'($urandom);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 20);
        if (!out_valid) lat = 99;
        rs = sum; rc = cout; ro = overflow;
        if (retire) begin
            saved = out_ready;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = saved;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++;
        if ({in_ready, out_valid, sum, cout, overflow} !== 20'h0) begin
            fails++;
            $display("FAIL reset_state: got rdy=%b vld=%b sum=%h cout=%b ovf=%b, want all 0",
                     in_ready, out_valid, sum, cout, overflow);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL ready_before_edge: got %b want 0", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_release: got %b want 1", in_ready);
        end
    endtask

    task automatic test_add();
        logic [15:0] va [5] = '{16'h0001, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h1234};
        logic [15:0] vb [5] = '{16'h0001, 16'h0001, 16'hFFFF, 16'h0001, 16'h4321};
        logic        vc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [15:0] es [5] = '{16'h0002, 16'h0000, 16'hFFFF, 16'h8000, 16'h5556};
        logic        ec [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic        eo [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [15:0] rs;
        logic        rc, ro;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            do_op(va[i], vb[i], 1'b0, vc[i], 1'b1, rs, rc, ro, lat);
            checks++;
            if (lat !== 4) begin
                fails++;
                $display("FAIL add%0d_latency: got %0d want 4", i, lat);
            end
            checks++;
            if ({rs, rc, ro} !== {es[i], ec[i], eo[i]}) begin
                fails++;
                $display("FAIL add%0d_result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                         i, rs, rc, ro, es[i], ec[i], eo[i]);
            end
        end
        // Result stays on sum in IDLE after retirement
        checks++;
        if (sum !== 16'h5556 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL idle_hold: got sum=%h vld=%b want sum=5556 vld=0", sum, out_valid);
        end
    endtask

    task automatic test_sub();
        logic [15:0] va [3] = '{16'h0005, 16'h8000, 16'h0010};
        logic [15:0] vb [3] = '{16'h0007, 16'h0001, 16'h0010};
        logic [15:0] es [3] = '{16'hFFFE, 16'h7FFF, 16'h0000};
        logic        ec [3] = '{1'b0, 1'b1, 1'b1};
        logic        eo [3] = '{1'b0, 1'b1, 1'b0};
        logic [15:0] rs;
        logic        rc, ro;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            // cin=1 must be ignored for subtract
            do_op(va[i], vb[i], 1'b1, 1'b1, 1'b1, rs, rc, ro, lat);
            checks++;
            if ({rs, rc, ro} !== {es[i], ec[i], eo[i]} || lat !== 4) begin
                fails++;
                $display("FAIL sub%0d_result: got sum=%h cout=%b ovf=%b lat=%0d want sum=%h cout=%b ovf=%b lat=4",
                         i, rs, rc, ro, lat, es[i], ec[i], eo[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] rs;
        logic        rc, ro;
        int          lat;
        out_ready = 1'b0;
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, rs, rc, ro, lat);
        op_a = 16'h0F0F; op_b = 16'h00F1; op_sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, in_ready, sum, cout, overflow} !== {1'b1, 1'b0, 16'h8000, 1'b0, 1'b1}) begin
                fails++;
                $display("FAIL hold%0d: got vld=%b rdy=%b sum=%h cout=%b ovf=%b want vld=1 rdy=0 sum=8000 cout=0 ovf=1",
                         i, out_valid, in_ready, sum, cout, overflow);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL retire: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL next_accept: got rdy=%b want 0", in_ready);
        end
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 20);
        checks++;
        if (lat !== 4 || {sum, cout, overflow} !== {16'h1000, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL bp_next_result: got lat=%0d sum=%h cout=%b ovf=%b want lat=4 sum=1000 cout=0 ovf=0",
                     lat, sum, cout, overflow);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] rs;
        logic        rc, ro;
        int          lat;
        // out_ready held high through RUN has no effect before DONE
        out_ready = 1'b1;
        do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1, rs, rc, ro, lat);
        checks++;
        if ({rs, rc, ro} !== {16'h0100, 1'b0, 1'b0} || lat !== 4) begin
            fails++;
            $display("FAIL b2b0: got sum=%h cout=%b ovf=%b lat=%0d want sum=0100 cout=0 ovf=0 lat=4",
                     rs, rc, ro, lat);
        end
        do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, rs, rc, ro, lat);
        checks++;
        if ({rs, rc, ro} !== {16'h0000, 1'b1, 1'b1} || lat !== 4) begin
            fails++;
            $display("FAIL b2b1: got sum=%h cout=%b ovf=%b lat=%0d want sum=0000 cout=1 ovf=1 lat=4",
                     rs, rc, ro, lat);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_abort();
        logic [15:0] rs;
        logic        rc, ro;
        int          lat;
        @(negedge clk);
        op_a = 16'hAAAA; op_b = 16'h5555; op_sub = 1'b0; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, in_ready, sum} !== 18'h0) begin
            fails++;
            $display("FAIL abort_immediate: got vld=%b rdy=%b sum=%h want 0 0 0000",
                     out_valid, in_ready, sum);
        end
        repeat (6) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL abort_no_result: got vld=%b want 0", out_valid);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, rs, rc, ro, lat);
        checks++;
        if ({rs, rc, ro} !== {16'h5555, 1'b0, 1'b0} || lat !== 4) begin
            fails++;
            $display("FAIL post_reset_add: got sum=%h cout=%b ovf=%b lat=%0d want sum=5555 cout=0 ovf=0 lat=4",
                     rs, rc, ro, lat);
        end
    endtask

    initial begin
        checks = 0;
        fails = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        op_a = '0;
        op_b = '0;
        op_sub = 1'b0;
        cin = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
